// File: rtl/uart_alu_host.sv
// Host-side UART ALU command initiator: serialises opcode/A/B into the TX FIFO and returns the result byte.
// Optional response watchdog enabled by defining UART_HOST_TIMEOUT_EN.
module uart_alu_host #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned OPCODE_SZ      = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_W      = 20
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [OPCODE_SZ-1:0]  i_op_code,
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_timeout,
    output logic                  o_stray_rx,
    output logic                  o_busy,
    input  logic                  i_tx_full,
    output logic                  o_wr_uart,
    output logic [DATA_WIDTH-1:0] o_w_data,
    input  logic                  i_rx_empty,
    input  logic [DATA_WIDTH-1:0] i_r_data,
    output logic                  o_rd_uart
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_OPC = 3'd1,
        SEND_A   = 3'd2,
        SEND_B   = 3'd3,
        WAIT_RSP = 3'd4,
        RESP     = 3'd5
    } state_t;

    // Parameter sanity: opcode must fit a UART word, watchdog counter must reach its limit.
    if (OPCODE_SZ > DATA_WIDTH || 64'(TIMEOUT_CYCLES) > (64'd1 << TIMEOUT_W)) begin : g_param_check
        $error("uart_alu_host: illegal parameter combination");
    end

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] opc_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] rsp_q;

`ifdef UART_HOST_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 timeout_q;
    logic                 wd_expire;

    assign wd_expire     = (wd_cnt == WD_LAST);
    assign o_rsp_timeout = timeout_q;
`else
    assign o_rsp_timeout = 1'b0;
`endif

    assign o_rsp_data = rsp_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (i_cmd_valid) state_nxt = SEND_OPC;
            SEND_OPC: if (!i_tx_full) state_nxt = SEND_A;
            SEND_A:   if (!i_tx_full) state_nxt = SEND_B;
            SEND_B:   if (!i_tx_full) state_nxt = WAIT_RSP;
            WAIT_RSP: begin
                if (!i_rx_empty) state_nxt = RESP;
`ifdef UART_HOST_TIMEOUT_EN
                else if (wd_expire) state_nxt = RESP;
`endif
            end
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Handshake, FIFO strobes and TX data are decoded from state and FIFO flags.
    always_comb begin
        o_cmd_ready = 1'b0;
        o_busy      = 1'b1;
        o_rsp_valid = 1'b0;
        o_stray_rx  = 1'b0;
        o_wr_uart   = 1'b0;
        o_w_data    = '0;
        o_rd_uart   = 1'b0;
        case (state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
                o_rd_uart   = !i_rx_empty;
                o_stray_rx  = !i_rx_empty;
            end
            SEND_OPC: begin
                o_wr_uart = !i_tx_full;
                o_w_data  = opc_q;
            end
            SEND_A: begin
                o_wr_uart = !i_tx_full;
                o_w_data  = a_q;
            end
            SEND_B: begin
                o_wr_uart = !i_tx_full;
                o_w_data  = b_q;
            end
            WAIT_RSP: o_rd_uart = !i_rx_empty;
            RESP:     o_rsp_valid = 1'b1;
            default:  o_busy = 1'b1;
        endcase
    end

    // Command latches and response register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            opc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rsp_q <= '0;
        end else begin
            if (state == IDLE && i_cmd_valid) begin
                opc_q <= DATA_WIDTH'(i_op_code);
                a_q   <= i_op_a;
                b_q   <= i_op_b;
            end
            if (state == WAIT_RSP && !i_rx_empty) begin
                rsp_q <= i_r_data;
            end
`ifdef UART_HOST_TIMEOUT_EN
            else if (state == WAIT_RSP && wd_expire) begin
                rsp_q <= '0;
            end
`endif
        end
    end

`ifdef UART_HOST_TIMEOUT_EN
    // Watchdog: runs only while waiting; a byte arriving on the last cycle still wins.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == WAIT_RSP) begin
                wd_cnt <= wd_cnt + TIMEOUT_W'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (state == WAIT_RSP && !i_rx_empty) begin
                timeout_q <= 1'b0;
            end else if (state == WAIT_RSP && wd_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`endif

endmodule
